ddr3_dma_read_seq: RTL and testbench
====================================

# ddr3_dma_read_seq

Strided read sequencer for one client port of the 16-port DDR3 DMA read engine. A single start command describes a 2D region: `row_count` rows of `row_len` 512-bit words, with row start addresses spaced `row_stride` words apart. The block issues one DMA read request per row through the engine's req/ack port, limits the number of rows in flight, and counts completed rows from the engine's per-client data enables and end-of-packet flag. It reports done once every row has been delivered.

## Interface
- `MAX_OUTSTANDING`, default 2: maximum number of acked rows whose last beat has not yet arrived (1..15).
- `GAP`, default 4: minimum number of idle cycles between an ack and the next `read_req` assertion. This covers the engine's per-port re-request lockout.
- `clk` in 1: clock, shared with the DMA engine client side.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: single-cycle command pulse; ignored while `busy`.
- `base_addr` in 27: first row address, in 64-byte word units; sampled on accepted `start`.
- `row_len` in 27: words per row; sampled on accepted `start`.
- `row_stride` in 27: address increment between rows; sampled on accepted `start`.
- `row_count` in 16: number of rows; sampled on accepted `start`.
- `busy` out 1: command in progress.
- `done` out 1: single-cycle pulse when the command completes.
- `err` out 1: single-cycle pulse, asserted together with `done`, when a command is rejected.
- `read_req` out 1: request to the DMA port.
- `read_start_addr` out 27: row address presented with `read_req`.
- `read_length` out 27: row length presented with `read_req`.
- `read_ack` in 1: single-cycle grant from the DMA port.
- `dout_en_i` in 1: this client's bit of the engine's `dout_en`.
- `dout_eop` in 1: the engine's end-of-packet flag, qualified by `dout_en_i`.
- `rows_done` out 16: rows fully received in the current command.

## Operation
- State machine with four states: IDLE, REQ, GAP, DRAIN.
- IDLE:
  - On `start`, latch all command fields and set `next_addr = base_addr`, `rows_left = row_count`, `outstanding = 0`, `rows_done = 0`.
  - If `row_count == 0` or `row_len < 2`: pulse `done` and `err` on the next cycle and stay in IDLE with `busy` low.
  - Otherwise go to REQ.
- REQ:
  - `read_req` is high only when `outstanding < MAX_OUTSTANDING`.
  - `read_start_addr = next_addr` and `read_length = row_len`. Both are held stable the whole time `read_req` is high and for one cycle after `read_ack`.
  - On `read_ack`:
    - `read_req` drops on the next edge.
    - `next_addr += row_stride`, modulo 2^27 (wrap-around allowed, no error).
    - `rows_left -= 1` and `outstanding += 1`.
    - Go to GAP.
- GAP:
  - Count `GAP` cycles.
  - Then go to REQ if `rows_left != 0`, otherwise to DRAIN.
- DRAIN:
  - Wait for `outstanding == 0`.
  - Then pulse `done`, drop `busy`, and go to IDLE.
- Completion counting (all states):
  - Every cycle with `dout_en_i & dout_eop` does `outstanding -= 1` and `rows_done += 1`.
  - Ack and eop in the same cycle leave `outstanding` unchanged and still increment `rows_done`.
- `read_ack` while `read_req` is low is ignored. Eop while `outstanding == 0` is ignored; no underflow.

## Timing
- Reset values: `busy`, `done`, `err`, `read_req` = 0; `read_start_addr`, `read_length` = 0; `rows_done` = 0. State = IDLE.
- A reset mid-command returns to IDLE immediately. In-flight beats arriving after reset are ignored.
- `start` sampled at edge T gives `busy` = 1 and `read_req` = 1 from T+1.
- `read_ack` sampled at edge A gives `read_req` = 0 from A+1. The earliest next `read_req` is A+1+GAP.
- Eop beat sampled at edge E gives `rows_done` updated at E+1.
- In DRAIN with `outstanding` reaching 0 at edge D: `done` is high for the single cycle D+1, and `busy` is low from D+1.
- All outputs are registered; no combinational path from `read_ack`, `dout_en_i` or `dout_eop` to any output.

## Test plan
- Basic command (`base_addr` = 0x100, `row_len` = 4, `row_stride` = 0x10, `row_count` = 3, ack 2 cycles after each req, 4 beats + eop per row):
  - requests at 0x100, 0x110, 0x120, all with length 4;
  - `rows_done` = 3; `done` pulses once; `busy` low afterwards.
- Throttle (`MAX_OUTSTANDING` = 2, eop withheld):
  - exactly 2 acks occur and `read_req` stays low;
  - the third request appears only after the first eop.
- Spacing (back-to-back immediate acks): the gap from ack to the next `read_req` is at least 4 cycles, and address/length stay stable during each req.
- Boundary conditions:
  - `row_count` = 0 → `done` and `err` at T+1, no `read_req`;
  - `row_len` = 1 → same result;
  - `base_addr` = 0x7FFFFF0 with stride 0x20 → second address is 0x0000010.
- Simultaneous events: ack and eop coincide → `outstanding` is unchanged; `start` asserted while `busy` → ignored, with the command fields unchanged.
- Reset mid-command after 1 ack → every output returns to its reset value at the next cycle; late eop beats leave `rows_done` = 0.

Source files
------------

// File: rtl/ddr3_dma_read_seq_if.sv
// Client port of the DDR3 DMA read engine: row request/ack handshake plus this client's data enables.
interface ddr3_dma_read_seq_if;
  logic        read_req;
  logic [26:0] read_start_addr;
  logic [26:0] read_length;
  logic        read_ack;
  logic        dout_en_i;
  logic        dout_eop;

  modport master (
    output read_req, read_start_addr, read_length,
    input  read_ack, dout_en_i, dout_eop
  );

  modport slave (
    input  read_req, read_start_addr, read_length,
    output read_ack, dout_en_i, dout_eop
  );
endinterface

// File: rtl/ddr3_dma_read_seq.sv
// Strided 2D read sequencer: one DMA request per row, at most MAX_OUTSTANDING rows in flight, done when all land.
// Registered outputs; start -> read_req next cycle; requests stall while the in-flight limit is reached.
module ddr3_dma_read_seq #(
  parameter int MAX_OUTSTANDING = 2,
  parameter int GAP             = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [26:0] base_addr,
  input  logic [26:0] row_len,
  input  logic [26:0] row_stride,
  input  logic [15:0] row_count,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [15:0] rows_done,
  ddr3_dma_read_seq_if.master dma
);

  localparam int         GW    = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [3:0] MAX_O = 4'(MAX_OUTSTANDING);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_GAP, S_DRAIN} state_t;

  state_t          state_q, state_d;
  logic [26:0]     next_addr_q, next_addr_d;
  logic [26:0]     len_q, len_d;
  logic [26:0]     stride_q, stride_d;
  logic [15:0]     rows_left_q, rows_left_d;
  logic [3:0]      out_q, out_d;
  logic [15:0]     rows_done_q, rows_done_d;
  logic [GW-1:0]   gap_cnt_q, gap_cnt_d;
  logic            busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic            req_q, req_d;
  logic [26:0]     addr_q, addr_d, length_q, length_d;
  logic            ack_fire, eop_fire;

  always_comb begin
    state_d     = state_q;
    next_addr_d = next_addr_q;
    len_d       = len_q;
    stride_d    = stride_q;
    rows_left_d = rows_left_q;
    out_d       = out_q;
    rows_done_d = rows_done_q;
    gap_cnt_d   = gap_cnt_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    req_d       = req_q;
    addr_d      = addr_q;
    length_d    = length_q;

    // An eop with nothing in flight is a stray beat; an ack with req low is not a grant.
    ack_fire = req_q & dma.read_ack;
    eop_fire = dma.dout_en_i & dma.dout_eop & (out_q != 4'd0);

    if (eop_fire) rows_done_d = rows_done_q + 16'd1;
    case ({ack_fire, eop_fire})
      2'b10:   out_d = out_q + 4'd1;
      2'b01:   out_d = out_q - 4'd1;
      default: out_d = out_q;
    endcase

    case (state_q)
      S_IDLE: begin
        if (start) begin
          next_addr_d = base_addr;
          len_d       = row_len;
          stride_d    = row_stride;
          rows_left_d = row_count;
          out_d       = 4'd0;
          rows_done_d = 16'd0;
          if (row_count == 16'd0 || row_len < 27'd2) begin
            done_d = 1'b1;
            err_d  = 1'b1;
          end else begin
            state_d  = S_REQ;
            busy_d   = 1'b1;
            req_d    = 1'b1;
            addr_d   = base_addr;
            length_d = row_len;
          end
        end
      end
      S_REQ: begin
        if (ack_fire) begin
          req_d       = 1'b0;
          next_addr_d = next_addr_q + stride_q;
          rows_left_d = rows_left_q - 16'd1;
          gap_cnt_d   = '0;
          state_d     = S_GAP;
        end else begin
          req_d = (out_d < MAX_O);
        end
      end
      S_GAP: begin
        if (gap_cnt_q == GW'(GAP - 1)) begin
          if (rows_left_q != 16'd0) begin
            state_d  = S_REQ;
            req_d    = (out_d < MAX_O);
            addr_d   = next_addr_q;
            length_d = len_q;
          end else begin
            state_d = S_DRAIN;
          end
        end else begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end
      end
      S_DRAIN: begin
        if (out_d == 4'd0) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      next_addr_q <= '0;
      len_q       <= '0;
      stride_q    <= '0;
      rows_left_q <= '0;
      out_q       <= '0;
      rows_done_q <= '0;
      gap_cnt_q   <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      req_q       <= 1'b0;
      addr_q      <= '0;
      length_q    <= '0;
    end else begin
      state_q     <= state_d;
      next_addr_q <= next_addr_d;
      len_q       <= len_d;
      stride_q    <= stride_d;
      rows_left_q <= rows_left_d;
      out_q       <= out_d;
      rows_done_q <= rows_done_d;
      gap_cnt_q   <= gap_cnt_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      req_q       <= req_d;
      addr_q      <= addr_d;
      length_q    <= length_d;
    end
  end

  assign busy                = busy_q;
  assign done                = done_q;
  assign err                 = err_q;
  assign rows_done           = rows_done_q;
  assign dma.read_req        = req_q;
  assign dma.read_start_addr = addr_q;
  assign dma.read_length     = length_q;

endmodule

// File: tb/tb_ddr3_dma_read_seq.sv
// Bench for ddr3_dma_read_seq: engine responder, cycle-level reference model, directed command scenarios.
module tb_ddr3_dma_read_seq;

  localparam int MAXO = 2;
  localparam int GAPC = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [26:0] base_addr, row_len, row_stride;
  logic [15:0] row_count;
  logic        busy, done, err;
  logic [15:0] rows_done;

  ddr3_dma_read_seq_if sif ();

  ddr3_dma_read_seq #(.MAX_OUTSTANDING(MAXO), .GAP(GAPC)) dut (
    .clk(clk), .rst(rst), .start(start),
    .base_addr(base_addr), .row_len(row_len), .row_stride(row_stride), .row_count(row_count),
    .busy(busy), .done(done), .err(err), .rows_done(rows_done),
    .dma(sif)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Engine responder controls (written by the main sequence only)
  bit auto_ack  = 1'b0;
  bit auto_data = 1'b0;
  int ack_delay = 0;
  int man_ack   = 0;
  int man_eop   = 0;
  int flush_req = 0;

  // Engine observations (written by the engine only)
  logic [26:0] fired_addr[$];
  logic [26:0] fired_len[$];
  int          fired_cyc[$];
  int          eop_cyc[$];
  int          rows_q[$];

  initial begin : engine
    int wait_cnt, beat_idx, ack_seen, eop_seen, flush_seen;
    wait_cnt = 0; beat_idx = 0; ack_seen = 0; eop_seen = 0; flush_seen = 0;
    sif.read_ack  = 1'b0;
    sif.dout_en_i = 1'b0;
    sif.dout_eop  = 1'b0;
    forever begin
      @(negedge clk);
      if (sif.read_req && sif.read_ack) begin
        fired_addr.push_back(sif.read_start_addr);
        fired_len.push_back(sif.read_length);
        fired_cyc.push_back(cyc);
        rows_q.push_back(int'(sif.read_length));
      end
      if (flush_seen != flush_req) begin
        rows_q.delete();
        beat_idx   = 0;
        flush_seen = flush_req;
      end
      @(posedge clk); #1;
      sif.read_ack = 1'b0;
      if (ack_seen != man_ack) begin
        sif.read_ack = 1'b1;
        ack_seen++;
      end else if (auto_ack && sif.read_req) begin
        if (wait_cnt >= ack_delay) begin sif.read_ack = 1'b1; wait_cnt = 0; end
        else wait_cnt++;
      end else begin
        wait_cnt = 0;
      end
      sif.dout_en_i = 1'b0;
      sif.dout_eop  = 1'b0;
      if (eop_seen != man_eop) begin
        sif.dout_en_i = 1'b1;
        sif.dout_eop  = 1'b1;
        eop_seen++;
      end else if (auto_data && rows_q.size() > 0) begin
        sif.dout_en_i = 1'b1;
        if (beat_idx == rows_q[0] - 1) begin
          sif.dout_eop = 1'b1;
          eop_cyc.push_back(cyc);
          void'(rows_q.pop_front());
          beat_idx = 0;
        end else begin
          beat_idx++;
        end
      end
    end
  end

  // Reference model: command-level bookkeeping of issued rows, rows in flight and milestone cycles.
  int busy_from = -1, done_cycle = -1, err_cycle = -1, ready_cycle = 0, last_a = -100;
  int issued = 0, exp_out = 0, exp_rd = 0, m_cnt = 0, done_cnt = 0, min_gap = 1000;
  logic [26:0] m_base = '0, m_len = '0, m_stride = '0;
  bit zero_addr = 1'b1, prev_req = 1'b0;

  initial begin : compare
    bit e_busy, e_req, fire, eopv;
    logic [26:0] ea;
    forever begin
      @(negedge clk);
      e_busy = (busy_from >= 0) && (cyc >= busy_from) && (done_cycle < 0 || cyc < done_cycle);
      e_req  = e_busy && (issued < m_cnt) && (cyc >= ready_cycle) && (exp_out < MAXO);
      chk("busy", busy, e_busy);
      chk("done", done, cyc == done_cycle);
      chk("err", err, cyc == err_cycle);
      chk("read_req", sif.read_req, e_req);
      chk("rows_done", rows_done, exp_rd);
      if (zero_addr) begin
        chk("addr_rst", sif.read_start_addr, 0);
        chk("len_rst", sif.read_length, 0);
      end else if (e_req || cyc == last_a) begin
        ea = m_base + 27'(e_req ? issued : issued - 1) * m_stride;
        chk("req_addr", sif.read_start_addr, ea);
        chk("req_len", sif.read_length, m_len);
      end
      if (done) done_cnt++;
      if (sif.read_req && !prev_req && last_a >= 0 && (cyc - last_a) < min_gap) min_gap = cyc - last_a;
      prev_req = sif.read_req;

      if (rst) begin
        busy_from = -1; done_cycle = -1; err_cycle = -1; ready_cycle = 0; last_a = -100;
        issued = 0; exp_out = 0; exp_rd = 0; m_cnt = 0; zero_addr = 1'b1;
      end else if (start && !e_busy) begin
        m_base = base_addr; m_len = row_len; m_stride = row_stride; m_cnt = int'(row_count);
        exp_out = 0; exp_rd = 0; issued = 0; last_a = -100;
        if (row_count == 0 || row_len < 2) begin
          done_cycle = cyc + 1; err_cycle = cyc + 1; busy_from = -1;
        end else begin
          busy_from = cyc + 1; ready_cycle = cyc + 1; done_cycle = -1; zero_addr = 1'b0;
        end
      end else begin
        fire = e_req && sif.read_ack;
        eopv = sif.dout_en_i && sif.dout_eop && exp_out > 0;
        if (fire) begin
          issued++;
          last_a      = cyc + 1;
          ready_cycle = cyc + 1 + GAPC;
        end
        if (eopv) exp_rd++;
        exp_out = exp_out + int'(fire) - int'(eopv);
        if (eopv && exp_out == 0 && e_busy && issued == m_cnt)
          done_cycle = (last_a + GAPC + 1 > cyc + 1) ? last_a + GAPC + 1 : cyc + 1;
      end
    end
  end

  task automatic cmd(input logic [26:0] b, input logic [26:0] l, input logic [26:0] s, input logic [15:0] n);
    @(posedge clk); #1;
    start = 1'b1; base_addr = b; row_len = l; row_stride = s; row_count = n;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int limit, input string name);
    int k = 0;
    while (k < limit) begin
      @(negedge clk);
      if (done) break;
      k++;
    end
    chk(name, k < limit, 1);
  endtask

  task automatic wait_fires(input int n, input int limit, input string name);
    int k = 0;
    while (fired_addr.size() < n && k < limit) begin @(negedge clk); k++; end
    chk(name, fired_addr.size() >= n, 1);
  endtask

  task automatic wait_req(input int limit, input string name);
    int k = 0;
    do begin @(negedge clk); k++; end while (!sif.read_req && k < limit);
    chk(name, sif.read_req, 1);
  endtask

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : main
    int f0, d0, e0;
    rst = 1'b1; start = 1'b0;
    base_addr = '0; row_len = '0; row_stride = '0; row_count = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_busy", busy, 0);
    chk("reset_req", sif.read_req, 0);
    chk("reset_rows_done", rows_done, 0);

    // Basic three-row command, ack two cycles after each request
    auto_ack = 1'b1; ack_delay = 2; auto_data = 1'b1;
    f0 = fired_addr.size(); d0 = done_cnt;
    cmd(27'h100, 27'd4, 27'h10, 16'd3);
    wait_done(400, "basic_done_timeout");
    repeat (5) @(negedge clk);
    chk("basic_nreq", fired_addr.size() - f0, 3);
    chk("basic_addr0", fired_addr[f0], 27'h100);
    chk("basic_addr1", fired_addr[f0 + 1], 27'h110);
    chk("basic_addr2", fired_addr[f0 + 2], 27'h120);
    chk("basic_len", fired_len[f0 + 2], 4);
    chk("basic_rows_done", rows_done, 3);
    chk("basic_done_once", done_cnt - d0, 1);
    chk("basic_busy_after", busy, 0);

    // Throttle: eop withheld, immediate acks
    auto_data = 1'b0; ack_delay = 0;
    f0 = fired_addr.size(); e0 = eop_cyc.size();
    cmd(27'h0, 27'd3, 27'h8, 16'd4);
    repeat (30) @(negedge clk);
    chk("throttle_acks", fired_addr.size() - f0, 2);
    chk("throttle_req_low", sif.read_req, 0);
    chk("throttle_busy", busy, 1);
    auto_data = 1'b1;
    wait_done(400, "throttle_done_timeout");
    chk("throttle_nreq", fired_addr.size() - f0, 4);
    chk("throttle_third_after_eop", fired_cyc[f0 + 2] > eop_cyc[e0], 1);
    chk("throttle_rows_done", rows_done, 4);
    chk("spacing_min_gap", min_gap >= GAPC, 1);

    // Rejected commands
    cmd(27'h55, 27'd4, 27'd1, 16'd0);
    @(negedge clk);
    chk("cnt0_done", done, 1);
    chk("cnt0_err", err, 1);
    chk("cnt0_req", sif.read_req, 0);
    @(negedge clk);
    chk("cnt0_done_clear", done, 0);
    cmd(27'h55, 27'd1, 27'd1, 16'd5);
    @(negedge clk);
    chk("len1_done", done, 1);
    chk("len1_err", err, 1);
    chk("len1_busy", busy, 0);

    // Address wrap at 2^27
    ack_delay = 1;
    f0 = fired_addr.size();
    cmd(27'h7FFFFF0, 27'd2, 27'h20, 16'd2);
    wait_done(400, "wrap_done_timeout");
    chk("wrap_addr0", fired_addr[f0], 27'h7FFFFF0);
    chk("wrap_addr1", fired_addr[f0 + 1], 27'h0000010);

    // Coincident ack+eop, and start while busy
    auto_ack = 1'b0; auto_data = 1'b0;
    flush_req++;
    cmd(27'h40, 27'd2, 27'd4, 16'd3);
    wait_req(20, "coin_req0_timeout");
    man_ack++;
    repeat (3) @(negedge clk);
    wait_req(20, "coin_req1_timeout");
    man_ack++; man_eop++;
    cmd(27'h999, 27'd7, 27'd1, 16'd1);
    wait_req(20, "coin_req2_timeout");
    chk("coin_addr2", sif.read_start_addr, 27'h48);
    chk("coin_len2", sif.read_length, 2);
    chk("coin_rows_done", rows_done, 1);
    man_ack++;
    repeat (3) @(negedge clk);
    man_eop++;
    repeat (2) @(negedge clk);
    man_eop++;
    wait_done(100, "coin_done_timeout");
    chk("coin_rows_done_final", rows_done, 3);
    flush_req++;

    // Reset mid-command after one ack; late beats must not count
    auto_ack = 1'b1; ack_delay = 0;
    f0 = fired_addr.size();
    cmd(27'h200, 27'd4, 27'd4, 16'd3);
    wait_fires(f0 + 1, 50, "midrst_ack_timeout");
    auto_ack = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_err", err, 0);
    chk("midrst_req", sif.read_req, 0);
    chk("midrst_addr", sif.read_start_addr, 0);
    chk("midrst_len", sif.read_length, 0);
    man_eop++;
    @(negedge clk);
    man_eop++;
    repeat (6) @(negedge clk);
    chk("midrst_late_eop", rows_done, 0);
    flush_req++;

    repeat (5) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
